// File: rtl/tnn_feature_sequencer.sv
// Serial-to-parallel front end for the combinational TNN classifiers: builds a 7-feature frame,
// holds it on feat_a..feat_g, then samples cls_in. Define TNN_SEQ_STATS_EN for result counters.
module tnn_feature_sequencer #(
  parameter int NUM_FEAT      = 7,
  parameter int FEAT_W        = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic [FEAT_W-1:0] feat_a,
  output logic [FEAT_W-1:0] feat_b,
  output logic [FEAT_W-1:0] feat_c,
  output logic [FEAT_W-1:0] feat_d,
  output logic [FEAT_W-1:0] feat_e,
  output logic [FEAT_W-1:0] feat_f,
  output logic [FEAT_W-1:0] feat_g,
  input  logic              cls_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_class,
  output logic              m_err
`ifdef TNN_SEQ_STATS_EN
  ,
  output logic [15:0]       stat_frames,
  output logic [15:0]       stat_pos,
  output logic [15:0]       stat_err
`endif
);

  localparam int                CNT_W       = $clog2(NUM_FEAT);
  localparam logic [CNT_W-1:0]  LAST_IDX    = CNT_W'(NUM_FEAT - 1);
  localparam logic [3:0]        SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {COLLECT, DRAIN, EVAL, HOLD} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   count;
  logic [3:0]         settle_cnt;
  logic               err;
  logic               beat;
  logic               enter_eval;
  logic [FEAT_W-1:0]  feat [NUM_FEAT];

  assign feat_a = feat[0];
  assign feat_b = feat[1];
  assign feat_c = feat[2];
  assign feat_d = feat[3];
  assign feat_e = feat[4];
  assign feat_f = feat[5];
  assign feat_g = feat[6];

  always_comb begin
    beat       = s_valid & s_ready;
    state_next = state;
    case (state)
      COLLECT: begin
        if (beat) begin
          if (count == LAST_IDX && !s_last) state_next = DRAIN;
          else if (s_last || count == LAST_IDX) state_next = EVAL;
        end
      end
      DRAIN:   if (beat && s_last) state_next = EVAL;
      EVAL:    if (settle_cnt == '0) state_next = HOLD;
      HOLD:    if (m_ready) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
    enter_eval = (state_next == EVAL) && (state != EVAL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= COLLECT;
      count      <= '0;
      settle_cnt <= '0;
      err        <= 1'b0;
      s_ready    <= 1'b1;
      m_valid    <= 1'b0;
      m_class    <= 1'b0;
      m_err      <= 1'b0;
      for (int i = 0; i < NUM_FEAT; i++) feat[i] <= '0;
    end else begin
      state   <= state_next;
      // s_ready follows the next state so it never depends on s_valid combinationally
      s_ready <= (state_next == COLLECT) || (state_next == DRAIN);
      if (enter_eval) settle_cnt <= SETTLE_INIT;
      else if (state == EVAL && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
      case (state)
        COLLECT: begin
          if (beat) begin
            // an early s_last zero-fills the unused upper slots
            for (int i = 0; i < NUM_FEAT; i++)
              if (s_last && i > int'(count)) feat[i] <= '0;
            feat[count] <= s_data;
            count       <= count + 1'b1;
            if (s_last || count == LAST_IDX) err <= ~(s_last & (count == LAST_IDX));
          end
        end
        EVAL: begin
          if (settle_cnt == '0) begin
            m_class <= cls_in;
            m_err   <= err;
            m_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            count   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TNN_SEQ_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_frames <= '0;
      stat_pos    <= '0;
      stat_err    <= '0;
    end else if (m_valid && m_ready) begin
      stat_frames <= sat_inc(stat_frames);
      if (m_class) stat_pos <= sat_inc(stat_pos);
      if (m_err)   stat_err <= sat_inc(stat_err);
    end
  end
`endif

endmodule

// File: tb/tb_tnn_feature_sequencer.sv
// Scoreboard bench for tnn_feature_sequencer: driver pushes expected results per frame,
// a negedge monitor pops and compares on each result handshake.
module tb_tnn_feature_sequencer;

  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_ready, s_last;
  logic [1:0] s_data;
  logic [1:0] feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g;
  logic       cls_in;
  logic       m_valid, m_ready, m_class, m_err;
`ifdef TNN_SEQ_STATS_EN
  logic [15:0] stat_frames, stat_pos, stat_err;
`endif

  tnn_feature_sequencer #(.NUM_FEAT(7), .FEAT_W(2), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .feat_a(feat_a), .feat_b(feat_b), .feat_c(feat_c), .feat_d(feat_d),
    .feat_e(feat_e), .feat_f(feat_f), .feat_g(feat_g),
    .cls_in(cls_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_err(m_err)
`ifdef TNN_SEQ_STATS_EN
    , .stat_frames(stat_frames), .stat_pos(stat_pos), .stat_err(stat_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Classifier stub: mode 0 = feat_a[1], mode 1 = parity of the whole frame
  logic cls_mode = 1'b0;
  assign cls_in = cls_mode ? ^{feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g} : feat_a[1];

  typedef struct {
    logic [13:0] feats;
    logic        cls;
    logic        err;
    int          due;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  int         ready_mode = 1;   // 0 random, 1 always ready, 2 stall 5 cycles
  logic [1:0] beats [16];
  int         exp_frames = 0, exp_pos = 0, exp_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected frame: first min(len,7) beats in order, zeros beyond, error unless exactly 7 beats
  task automatic send_frame(input int len, input bit push);
    exp_t        e;
    logic [1:0]  f [7];
    int          t;
    for (int i = 0; i < 7; i++) f[i] = (i < len) ? beats[i] : 2'd0;
    e.feats = {f[0], f[1], f[2], f[3], f[4], f[5], f[6]};
    e.cls   = cls_mode ? ^e.feats : f[0][1];
    e.err   = (len != 7);
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        s_data  = 2'($urandom);
        s_last  = 1'($urandom);
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = beats[i];
      s_last  = (i == len - 1);
      t = 0;
      while (!s_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        failures++;
        $display("FAIL s_ready_timeout: beat %0d never accepted", i);
      end
      if (i == len - 1 && push) begin
        e.due = cyc + SETTLE + 1;
        q.push_back(e);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (q.size() != 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      failures++;
      $display("FAIL result_timeout: %0d results outstanding", q.size());
    end
    @(negedge clk);
  endtask

  bit mon_on = 1'b0;
  bit prev_mv = 1'b0, prev_rdy = 1'b0;
  int hv = 0;

  initial m_ready = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (prev_mv && !prev_rdy) chk("m_valid_held", 32'(m_valid), 32'd1);
      if (prev_mv && prev_rdy) begin
        chk("post_hs_m_valid", 32'(m_valid), 32'd0);
        chk("post_hs_s_ready", 32'(s_ready), 32'd1);
      end
      if (m_valid === 1'b1) begin
        if (!prev_mv) begin
          hv = 0;
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: m_valid=1 required no result (cycle %0d)", cyc);
          end else chk("latency", 32'(cyc), 32'(q[0].due));
        end
        case (ready_mode)
          0:       m_ready = 1'($urandom_range(0, 1));
          2:       m_ready = (hv >= 5);
          default: m_ready = 1'b1;
        endcase
        hv++;
        if (q.size() != 0) begin
          chk("m_class", 32'(m_class), 32'(q[0].cls));
          chk("m_err", 32'(m_err), 32'(q[0].err));
          chk("feats", 32'({feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g}), 32'(q[0].feats));
          chk("s_ready_in_hold", 32'(s_ready), 32'd0);
          if (m_ready) begin
            exp_frames++;
            exp_pos  += int'(q[0].cls);
            exp_errs += int'(q[0].err);
            void'(q.pop_front());
          end
        end
      end else begin
        m_ready = (ready_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      prev_mv  = (m_valid === 1'b1);
      prev_rdy = m_ready;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = 2'd0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_class", 32'(m_class), 32'd0);
    chk("rst_m_err", 32'(m_err), 32'd0);
    chk("rst_feats", 32'({feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g}), 32'd0);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);

    // Nominal frame 1,2,3,0,1,2,3
    beats[0] = 2'd1; beats[1] = 2'd2; beats[2] = 2'd3; beats[3] = 2'd0;
    beats[4] = 2'd1; beats[5] = 2'd2; beats[6] = 2'd3;
    send_frame(7, 1'b1);
    wait_idle();

    // Same frame with feat_a=2 and consumer stalling 5 cycles
    ready_mode = 2;
    beats[0] = 2'd2;
    send_frame(7, 1'b1);
    wait_idle();
    ready_mode = 1;

    // Short frame 3,3,3
    for (int i = 0; i < 3; i++) beats[i] = 2'd3;
    send_frame(3, 1'b1);
    wait_idle();

    // Overlong frame of 10 beats
    for (int i = 0; i < 10; i++) beats[i] = 2'($urandom);
    send_frame(10, 1'b1);
    wait_idle();

    // Reset while the frame is in EVAL
    for (int i = 0; i < 7; i++) beats[i] = 2'($urandom_range(1, 3));
    send_frame(7, 1'b0);
    chk("eval_no_valid", 32'(m_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_eval_m_valid", 32'(m_valid), 32'd0);
    chk("rst_eval_s_ready", 32'(s_ready), 32'd1);
    chk("rst_eval_feats", 32'({feat_a, feat_b, feat_c, feat_d, feat_e, feat_f, feat_g}), 32'd0);
    for (int i = 0; i < 7; i++) beats[i] = 2'($urandom);
    send_frame(7, 1'b1);
    wait_idle();

    // Randomized frames, mostly full length, random backpressure
    cls_mode   = 1'b1;
    ready_mode = 0;
    for (int n = 0; n < 40; n++) begin
      int len;
      len = ($urandom_range(0, 9) < 6) ? 7 : int'($urandom_range(1, 10));
      for (int i = 0; i < 16; i++) beats[i] = 2'($urandom);
      send_frame(len, 1'b1);
    end
    wait_idle();
    ready_mode = 1;
    repeat (3) @(negedge clk);

`ifdef TNN_SEQ_STATS_EN
    chk("stat_frames", 32'(stat_frames), 32'(exp_frames));
    chk("stat_pos", 32'(stat_pos), 32'(exp_pos));
    chk("stat_err", 32'(stat_err), 32'(exp_errs));
`endif
    chk("results_outstanding", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
